// File: rtl/decode_regfile_pipe.sv
// ---------------------------------------------------------------------------
// decode_regfile_pipe
//
// Decode-stage register file with per-port forwarding muxes and the ID/EX
// pipeline register. Sits between the IF/ID register and the execute stage.
//
// Optional feature (compile-time macro): GRF_BYPASS_EN
//   defined   : a register-file read of the address being written this cycle
//               returns the write data (write-through), so the hazard unit
//               need not forward the write-back stage.
//   undefined : reads return the stored entry only; the new value appears
//               the cycle after the write edge.
//
// Ports
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   rd_addr         NUM_RD read addresses, port i at [i*ADDR_W +: ADDR_W]
//   fwd_sel         NUM_RD selects: 0 = register file, k = fwd_data source k-1,
//                   values above FWD_SRC fall back to the register file
//   fwd_data        FWD_SRC forwarded values from later stages
//   we, wa, wd      register-file write port (entry 0 is hardwired to 0)
//   rd_data         combinational operands per port
//   d_instr, d_pc, d_ext, d_wra, d_valid   decode-stage fields
//   hold            keep the ID/EX register (wins over bubble)
//   bubble          load a nop into the ID/EX register
//   de_*            registered ID/EX fields
//   bubble_cnt      saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module decode_regfile_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int FWD_SRC = 3,
    localparam int SEL_W  = $clog2(FWD_SRC + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD*SEL_W-1:0]    fwd_sel,
    input  logic [FWD_SRC*DATA_W-1:0]  fwd_data,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic [31:0]                d_instr,
    input  logic [31:0]                d_pc,
    input  logic [DATA_W-1:0]          d_ext,
    input  logic [ADDR_W-1:0]          d_wra,
    input  logic                       d_valid,
    input  logic                       hold,
    input  logic                       bubble,
    output logic [NUM_RD*DATA_W-1:0]   de_rd,
    output logic [31:0]                de_instr,
    output logic [31:0]                de_pc,
    output logic [DATA_W-1:0]          de_ext,
    output logic [ADDR_W-1:0]          de_wra,
    output logic                       de_valid,
    output logic [15:0]                bubble_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the whole array is cleared because every entry must read 0
            // after reset; this deliberately rules out a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            rf_q[wa] <= wd;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with forwarding
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] rf_val;
        logic [DATA_W-1:0] fwd_val;
        logic              fwd_hit;

        assign addr = rd_addr[g*ADDR_W +: ADDR_W];
        assign sel  = fwd_sel[g*SEL_W +: SEL_W];

        always_comb begin
            // NOTE: defaults first so no path leaves a variable unassigned
            // (which would infer a latch).
            rf_val = (addr == '0) ? '0 : rf_q[addr];
`ifdef GRF_BYPASS_EN
            // Write-through: the entry being written this cycle is seen now.
            if (we && (wa != '0) && (wa == addr)) begin
                rf_val = wd;
            end
`endif
        end

        // Forwarding is not masked for address 0; out-of-range selects
        // fall back to the register file.
        always_comb begin
            fwd_val = '0;
            fwd_hit = 1'b0;
            for (int k = 0; k < FWD_SRC; k++) begin
                if (int'(sel) == k + 1) begin
                    fwd_val = fwd_data[k*DATA_W +: DATA_W];
                    fwd_hit = 1'b1;
                end
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = fwd_hit ? fwd_val : rf_val;
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic [NUM_RD*DATA_W-1:0] de_rd_q,    de_rd_d;
    logic [31:0]              de_instr_q, de_instr_d;
    logic [31:0]              de_pc_q,    de_pc_d;
    logic [DATA_W-1:0]        de_ext_q,   de_ext_d;
    logic [ADDR_W-1:0]        de_wra_q,   de_wra_d;
    logic                     de_valid_q, de_valid_d;
    logic [15:0]              cnt_q,      cnt_d;

    always_comb begin
        de_rd_d    = de_rd_q;
        de_instr_d = de_instr_q;
        de_pc_d    = de_pc_q;
        de_ext_d   = de_ext_q;
        de_wra_d   = de_wra_q;
        de_valid_d = de_valid_q;
        cnt_d      = cnt_q;
        if (hold) begin
            // Downstream stall: everything keeps its value.
        end else if (bubble) begin
            de_rd_d    = '0;
            de_instr_d = 32'h0000_0000;
            de_pc_d    = '0;
            de_ext_d   = '0;
            de_wra_d   = '0;
            de_valid_d = 1'b0;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            de_rd_d    = rd_data;
            de_instr_d = d_instr;
            de_pc_d    = d_pc;
            de_ext_d   = d_ext;
            de_wra_d   = d_wra;
            de_valid_d = d_valid;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_rd_q    <= '0;
            de_instr_q <= '0;
            de_pc_q    <= '0;
            de_ext_q   <= '0;
            de_wra_q   <= '0;
            de_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            de_rd_q    <= de_rd_d;
            de_instr_q <= de_instr_d;
            de_pc_q    <= de_pc_d;
            de_ext_q   <= de_ext_d;
            de_wra_q   <= de_wra_d;
            de_valid_q <= de_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign de_rd      = de_rd_q;
    assign de_instr   = de_instr_q;
    assign de_pc      = de_pc_q;
    assign de_ext     = de_ext_q;
    assign de_wra     = de_wra_q;
    assign de_valid   = de_valid_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_decode_regfile_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_regfile_pipe
//
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared against a behavioural model (array register file + plain ID/EX
// fields). Instantiated with FWD_SRC=2 so fwd_sel=3 is an out-of-range select.
// ---------------------------------------------------------------------------
module tb_decode_regfile_pipe;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_RD  = 2;
    localparam int FWD_SRC = 2;
    localparam int SEL_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD*SEL_W-1:0]   fwd_sel;
    logic [FWD_SRC*DATA_W-1:0] fwd_data;
    logic                      we;
    logic [ADDR_W-1:0]         wa;
    logic [DATA_W-1:0]         wd;
    logic [NUM_RD*DATA_W-1:0]  rd_data;
    logic [31:0]               d_instr;
    logic [31:0]               d_pc;
    logic [DATA_W-1:0]         d_ext;
    logic [ADDR_W-1:0]         d_wra;
    logic                      d_valid;
    logic                      hold;
    logic                      bubble;
    logic [NUM_RD*DATA_W-1:0]  de_rd;
    logic [31:0]               de_instr;
    logic [31:0]               de_pc;
    logic [DATA_W-1:0]         de_ext;
    logic [ADDR_W-1:0]         de_wra;
    logic                      de_valid;
    logic [15:0]               bubble_cnt;

    decode_regfile_pipe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .FWD_SRC(FWD_SRC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .fwd_sel   (fwd_sel),
        .fwd_data  (fwd_data),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .rd_data   (rd_data),
        .d_instr   (d_instr),
        .d_pc      (d_pc),
        .d_ext     (d_ext),
        .d_wra     (d_wra),
        .d_valid   (d_valid),
        .hold      (hold),
        .bubble    (bubble),
        .de_rd     (de_rd),
        .de_instr  (de_instr),
        .de_pc     (de_pc),
        .de_ext    (de_ext),
        .de_wra    (de_wra),
        .de_valid  (de_valid),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping and checker
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] m_rf [32];
    logic [63:0] m_de_rd;
    logic [31:0] m_instr, m_pc, m_ext;
    logic [4:0]  m_wra;
    logic        m_valid;
    int          m_cnt;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_de_rd = '0; m_instr = '0; m_pc = '0; m_ext = '0;
        m_wra = '0; m_valid = 1'b0; m_cnt = 0;
    endtask

    // Operand value a port should present, straight from the rules.
    function automatic logic [31:0] model_port(input int p);
        int sel;
        int addr;
        sel  = int'(fwd_sel[p*SEL_W +: SEL_W]);
        addr = int'(rd_addr[p*ADDR_W +: ADDR_W]);
        if (sel >= 1 && sel <= FWD_SRC) return fwd_data[(sel-1)*DATA_W +: DATA_W];
        if (addr == 0) return 32'h0;
`ifdef GRF_BYPASS_EN
        if (we && wa != 0 && int'(wa) == addr) return wd;
`endif
        return m_rf[addr];
    endfunction

    task automatic check_de(input string pfx);
        check({pfx, ".de_rd"},    de_rd,               m_de_rd);
        check({pfx, ".de_instr"}, {32'h0, de_instr},   {32'h0, m_instr});
        check({pfx, ".de_pc"},    {32'h0, de_pc},      {32'h0, m_pc});
        check({pfx, ".de_ext"},   {32'h0, de_ext},     {32'h0, m_ext});
        check({pfx, ".de_wra"},   {59'h0, de_wra},     {59'h0, m_wra});
        check({pfx, ".de_valid"}, {63'h0, de_valid},   {63'h0, m_valid});
        check({pfx, ".bubble_cnt"}, {48'h0, bubble_cnt}, 64'(m_cnt));
    endtask

    // One clock: check operands before the edge, advance the model at the
    // edge, check the ID/EX register just after it. Inputs must be stable.
    task automatic tick(input string pfx, input bit do_check_de);
        logic [63:0] exp_rd;
        #1;
        exp_rd = {model_port(1), model_port(0)};
        check({pfx, ".rd_data"}, rd_data, exp_rd);
        @(posedge clk);
        if (we && wa != 0) m_rf[wa] = wd;
        if (!hold) begin
            if (bubble) begin
                m_de_rd = '0; m_instr = '0; m_pc = '0; m_ext = '0;
                m_wra = '0; m_valid = 1'b0;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_de_rd = exp_rd; m_instr = d_instr; m_pc = d_pc;
                m_ext = d_ext; m_wra = d_wra; m_valid = d_valid;
            end
        end
        #1;
        if (do_check_de) check_de(pfx);
    endtask

    task automatic idle_inputs();
        rd_addr = '0; fwd_sel = '0; fwd_data = '0;
        we = 1'b0; wa = '0; wd = '0;
        d_instr = '0; d_pc = '0; d_ext = '0; d_wra = '0; d_valid = 1'b0;
        hold = 1'b0; bubble = 1'b0;
    endtask

    task automatic rand_inputs();
        rd_addr  = 10'($urandom);
        fwd_sel  = 4'($urandom);
        fwd_data = {$urandom, $urandom};
        we       = 1'($urandom);
        wa       = 5'($urandom);
        wd       = $urandom;
        if ($urandom_range(0, 3) == 0) rd_addr[4:0] = wa;
        if ($urandom_range(0, 3) == 0) rd_addr[9:5] = wa;
        d_instr  = $urandom;
        d_pc     = $urandom;
        d_ext    = $urandom;
        d_wra    = 5'($urandom);
        d_valid  = 1'($urandom);
        hold     = ($urandom_range(0, 7) == 0);
        bubble   = ($urandom_range(0, 5) == 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #2;
        check_de("por");
        @(negedge clk);
        reset = 1'b0;

        // Random traffic to populate the register file.
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            tick("rand_a", 1'b1);
        end

        // Mid-cycle asynchronous reset: everything clears without an edge.
        idle_inputs();
        rd_addr = {5'd7, 5'd5};
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_de("async_rst");
        check("async_rst.rd_data", rd_data, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Write to entry 0 is ignored.
        we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; rd_addr = '0;
        tick("wr_zero", 1'b1);
        we = 1'b0;
        #1;
        check("wr_zero.read0", rd_data, 64'h0);

        // Same-cycle write and read of entry 5.
        we = 1'b1; wa = 5'd5; wd = 32'h12345678; rd_addr = {5'd0, 5'd5}; fwd_sel = '0;
        #1;
`ifdef GRF_BYPASS_EN
        check("bypass.pre_edge", {32'h0, rd_data[31:0]}, 64'h12345678);
`else
        check("bypass.pre_edge", {32'h0, rd_data[31:0]}, 64'h0);
`endif
        tick("bypass", 1'b1);
        we = 1'b0;
        #1;
        check("bypass.post_edge", {32'h0, rd_data[31:0]}, 64'h12345678);

        // Forward select on port 1.
        fwd_data = {32'hAAAA0001, 32'h5555_0000};
        rd_addr  = {5'd5, 5'd0};
        fwd_sel  = {2'd2, 2'd0};
        #1;
        check("fwd.rd_data1", {32'h0, rd_data[63:32]}, 64'hAAAA0001);
        tick("fwd", 1'b1);
        check("fwd.de_rd1", {32'h0, de_rd[63:32]}, 64'hAAAA0001);
        fwd_sel = {2'd3, 2'd0};
        #1;
        check("fwd.out_of_range", {32'h0, rd_data[63:32]}, 64'h12345678);
        tick("fwd_oor", 1'b1);

        // Bubble with a real instruction pending.
        d_instr = 32'h8C220004; d_wra = 5'd2; d_valid = 1'b1; d_pc = 32'h100;
        bubble  = 1'b1;
        tick("bubble", 1'b1);
        check("bubble.cnt", {48'h0, bubble_cnt}, 64'd1);
        check("bubble.instr", {32'h0, de_instr}, 64'h0);

        // Load something, then hold+bubble for three cycles.
        bubble = 1'b0;
        tick("load", 1'b1);
        check("load.instr", {32'h0, de_instr}, 64'h8C220004);
        hold = 1'b1; bubble = 1'b1; d_instr = 32'h0BAD_0BAD; d_pc = 32'h200;
        for (int i = 0; i < 3; i++) tick("hold", 1'b1);
        check("hold.instr", {32'h0, de_instr}, 64'h8C220004);
        check("hold.cnt", {48'h0, bubble_cnt}, 64'd1);
        hold = 1'b0; bubble = 1'b0;
        tick("release", 1'b1);
        check("release.instr", {32'h0, de_instr}, 64'h0BAD0BAD);

        // More random traffic.
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            tick("rand_b", 1'b1);
        end

        // Saturation: reset then 65537 consecutive bubbles.
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        bubble = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            tick("sat", (i < 4) || (i > 65530));
        end
        check("sat.cnt", {48'h0, bubble_cnt}, 64'hFFFF);
        bubble = 1'b0;
        tick("sat_after", 1'b1);
        check("sat_after.cnt", {48'h0, bubble_cnt}, 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
